// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory port arbiter.
//   owner_t     : which requester received the previous cycle's grant
//   STALL_CNT_W : width of the saturating pipeline-stall counter
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_HOST = 2'd2
  } owner_t;

  localparam int unsigned STALL_CNT_W = 32;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
// Ports:
//   clk, arst : clock, asynchronous active-high reset
//   inc       : increment request (ignored once MAX is reached)
//   clr       : synchronous clear
//   cnt       : current count
module sat_counter #(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] MAX   = '1
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] cnt_q;

  // Next count: clear first, then increment only below the ceiling.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q < MAX)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single data-memory SRAM port between the pipeline MEM stage and a
// host/debug master. One grant per cycle; the host wins when the CPU is idle or
// after losing HOST_MAX_WAIT consecutive cycles. Read data (1-cycle latency) is
// steered back to whichever requester owned the previous cycle.
// Ports:
//   clk, arst            : clock, asynchronous active-high reset
//   enable               : CPU running; low hands the memory to the host
//   cpu_*                : MEM-stage request, cpu_stall freezes the pipeline
//   host_*               : host request/grant handshake, host_done one cycle after grant
//   mem_*                : SRAM port (mem_rdata has 1-cycle latency)
//   stall_cnt, _clr      : saturating count of stalled CPU cycles, synchronous clear
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W        = 10,
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned HOST_MAX_WAIT = 4
) (
  input  logic                   clk,
  input  logic                   arst,
  input  logic                   enable,
  input  logic                   cpu_ren,
  input  logic                   cpu_wen,
  input  logic [ADDR_W-1:0]      cpu_addr,
  input  logic [DATA_W-1:0]      cpu_wdata,
  output logic                   cpu_stall,
  output logic [DATA_W-1:0]      cpu_rdata,
  input  logic                   host_req,
  input  logic                   host_we,
  input  logic [ADDR_W-1:0]      host_addr,
  input  logic [DATA_W-1:0]      host_wdata,
  output logic                   host_gnt,
  output logic                   host_done,
  output logic [DATA_W-1:0]      host_rdata,
  output logic                   mem_ren,
  output logic                   mem_wen,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_wdata,
  input  logic [DATA_W-1:0]      mem_rdata,
  output logic [STALL_CNT_W-1:0] stall_cnt,
  input  logic                   stall_cnt_clr
);

  localparam int unsigned          STARVE_W   = $clog2(HOST_MAX_WAIT + 1);
  localparam logic [STARVE_W-1:0]  STARVE_MAX = STARVE_W'(HOST_MAX_WAIT);

  logic                cpu_req;
  logic                host_wins;
  logic                gnt_host;
  logic                gnt_cpu;
  logic [STARVE_W-1:0] starve;
  owner_t              owner_d, owner_q;
  logic                host_was_read_d, host_was_read_q;

  // Arbitration; every grant is held off while reset is asserted.
  always_comb begin
    cpu_req   = enable & (cpu_ren | cpu_wen);
    host_wins = host_req & (~cpu_req | (starve == STARVE_MAX));
    gnt_host  = ~arst & host_wins;
    gnt_cpu   = ~arst & ~host_wins & cpu_req;
    cpu_stall = ~arst & cpu_req & ~gnt_cpu;
    host_gnt  = gnt_host;
  end

  // SRAM port mux: idle port drives all zeros.
  always_comb begin
    mem_ren   = 1'b0;
    mem_wen   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt_host) begin
      mem_ren   = ~host_we;
      mem_wen   = host_we;
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
    end else if (gnt_cpu) begin
      mem_ren   = cpu_ren;
      mem_wen   = cpu_wen;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end
  end

  // Consecutive cycles a pending host request has lost to the CPU.
  sat_counter #(
    .WIDTH (STARVE_W),
    .MAX   (STARVE_MAX)
  ) u_starve_cnt (
    .clk  (clk),
    .arst (arst),
    .inc  (host_req & gnt_cpu),
    .clr  (gnt_host | ~host_req),
    .cnt  (starve)
  );

  sat_counter #(
    .WIDTH (STALL_CNT_W),
    .MAX   ({STALL_CNT_W{1'b1}})
  ) u_stall_cnt (
    .clk  (clk),
    .arst (arst),
    .inc  (cpu_stall),
    .clr  (stall_cnt_clr),
    .cnt  (stall_cnt)
  );

  // Owner of the access whose read data returns next cycle.
  always_comb begin
    owner_d         = OWN_NONE;
    host_was_read_d = 1'b0;
    if (gnt_host) begin
      owner_d         = OWN_HOST;
      host_was_read_d = ~host_we;
    end else if (gnt_cpu) begin
      owner_d = OWN_CPU;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      owner_q         <= OWN_NONE;
      host_was_read_q <= 1'b0;
    end else begin
      owner_q         <= owner_d;
      host_was_read_q <= host_was_read_d;
    end
  end

  // Return path: read data reaches only the previous cycle's owner.
  always_comb begin
    host_done  = (owner_q == OWN_HOST);
    host_rdata = (host_done && host_was_read_q) ? mem_rdata : '0;
    cpu_rdata  = (owner_q == OWN_CPU) ? mem_rdata : '0;
  end

  // A MEM stage that reads and writes in the same cycle is a pipeline bug.
  always @(posedge clk) begin
    if (!arst) begin
      assert (!(cpu_ren && cpu_wen))
        else $error("dmem_port_arbiter: cpu_ren and cpu_wen both high");
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Randomised bench for dmem_port_arbiter against a cycle-level behavioural model.
module tb_dmem_port_arbiter;

  localparam int AW  = 10;
  localparam int DW  = 32;
  localparam int HMW = 4;

  logic          clk = 1'b0;
  logic          arst;
  logic          enable, cpu_ren, cpu_wen, cpu_stall;
  logic [AW-1:0] cpu_addr, host_addr, mem_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata, host_wdata, host_rdata, mem_wdata, mem_rdata;
  logic          host_req, host_we, host_gnt, host_done, mem_ren, mem_wen;
  logic [31:0]   stall_cnt;
  logic          stall_cnt_clr;

  logic          sc_inc, sc_clr;
  logic [2:0]    sc_q;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .HOST_MAX_WAIT(HMW)) dut (
    .clk(clk), .arst(arst), .enable(enable),
    .cpu_ren(cpu_ren), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_done(host_done), .host_rdata(host_rdata),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_cnt(stall_cnt), .stall_cnt_clr(stall_cnt_clr)
  );

  // Small standalone counter so saturation and clear-priority are reachable.
  sat_counter #(.WIDTH(3), .MAX(3'd5)) u_sc (
    .clk(clk), .arst(arst), .inc(sc_inc), .clr(sc_clr), .cnt(sc_q)
  );

  // SRAM environment: synchronous write, registered 1-cycle read.
  logic [DW-1:0] sram [1024];
  always @(posedge clk) begin
    if (mem_wen) sram[mem_addr] <= mem_wdata;
    if (mem_ren) mem_rdata <= sram[mem_addr];
  end

  // Reference model state.
  logic [DW-1:0] ref_mem [1024];
  int            m_wait;
  int            m_prev;        // 0 none, 1 cpu, 2 host
  bit            m_prev_hread;
  logic [DW-1:0] m_last_rd;
  logic [31:0]   m_stall;
  bit            m_gh;
  bit            dut_gh;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_wait       = 0;
    m_prev       = 0;
    m_prev_hread = 0;
    m_stall      = 0;
  endtask

  // One clock cycle: inputs already applied at the falling edge.
  task automatic cyc();
    bit            creq, gh, gc, er, ew;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    #4;
    creq = enable && (cpu_ren || cpu_wen);
    gh   = host_req && (!creq || m_wait == HMW);
    gc   = creq && !gh;
    er = 0; ew = 0; ea = '0; ed = '0;
    if (gh) begin
      er = !host_we; ew = host_we; ea = host_addr; ed = host_wdata;
    end else if (gc) begin
      er = cpu_ren; ew = cpu_wen; ea = cpu_addr; ed = cpu_wdata;
    end
    check("host_gnt",   host_gnt,   gh);
    check("cpu_stall",  cpu_stall,  creq && !gc);
    check("mem_ren",    mem_ren,    er);
    check("mem_wen",    mem_wen,    ew);
    check("mem_addr",   mem_addr,   ea);
    check("mem_wdata",  mem_wdata,  ed);
    check("host_done",  host_done,  m_prev == 2);
    check("cpu_rdata",  cpu_rdata,  (m_prev == 1) ? m_last_rd : '0);
    check("host_rdata", host_rdata, (m_prev == 2 && m_prev_hread) ? m_last_rd : '0);
    check("stall_cnt",  stall_cnt,  m_stall);
    dut_gh = host_gnt;
    if (er) m_last_rd = ref_mem[ea];
    if (ew) ref_mem[ea] = ed;
    m_prev       = gh ? 2 : (gc ? 1 : 0);
    m_prev_hread = gh && !host_we;
    if (gh || !host_req)       m_wait = 0;
    else if (gc && m_wait < HMW) m_wait = m_wait + 1;
    if (stall_cnt_clr)                               m_stall = 0;
    else if (creq && !gc && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
    m_gh = gh;
    @(posedge clk);
    @(negedge clk);
  endtask

  // One cycle with reset asserted: everything observable must be quiet.
  task automatic rst_cycle();
    arst = 1'b1;
    #4;
    check("rst_host_gnt",   host_gnt,   1'b0);
    check("rst_cpu_stall",  cpu_stall,  1'b0);
    check("rst_mem_ren",    mem_ren,    1'b0);
    check("rst_mem_wen",    mem_wen,    1'b0);
    check("rst_host_done",  host_done,  1'b0);
    check("rst_host_rdata", host_rdata, '0);
    check("rst_cpu_rdata",  cpu_rdata,  '0);
    check("rst_stall_cnt",  stall_cnt,  '0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    arst = 1'b0;
  endtask

  task automatic new_host_req();
    host_req   = 1'b1;
    host_we    = 1'($urandom_range(0, 1));
    host_addr  = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
    host_wdata = $urandom;
  endtask

  initial begin
    logic [DW-1:0] v;
    int            op;
    arst = 1'b1;
    enable = 0; cpu_ren = 0; cpu_wen = 0; cpu_addr = '0; cpu_wdata = '0;
    host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
    stall_cnt_clr = 0; sc_inc = 0; sc_clr = 0;
    mem_rdata = '0; m_last_rd = '0;
    for (int i = 0; i < 1024; i++) begin
      v = $urandom;
      sram[i] = v;
      ref_mem[i] = v;
    end
    model_reset();
    @(negedge clk);
    rst_cycle();

    // CPU-only read
    enable = 1; cpu_ren = 1; cpu_addr = 10'h010;
    cyc();
    check("t1_cpu_rdata", cpu_rdata, ref_mem[16]);
    cpu_ren = 0;
    cyc();

    // Host-only write then back-to-back read while CPU halted
    enable = 0; cpu_ren = 1; cpu_addr = 10'h020;
    host_req = 1; host_we = 1; host_addr = 10'h3FF; host_wdata = 32'hDEAD_BEEF;
    cyc();
    host_we = 0;
    cyc();
    host_req = 0;
    check("t2_host_done",  host_done,  1'b1);
    check("t2_host_rdata", host_rdata, 32'hDEAD_BEEF);
    cpu_ren = 0;
    cyc();

    // Contention: host granted on cycle 5, single stall
    stall_cnt_clr = 1;
    cyc();
    stall_cnt_clr = 0;
    enable = 1; cpu_ren = 1; cpu_addr = 10'h011;
    host_req = 1; host_we = 0; host_addr = 10'h005;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("t3_gnt_cycle", dut_gh, (i == 4));
      if (m_gh) host_req = 0;
    end
    check("t3_stall_cnt", stall_cnt, 32'd1);
    cpu_ren = 0;

    // Idle CPU: host granted immediately
    host_req = 1;
    cyc();
    check("t4_host_gnt", dut_gh, 1'b1);
    host_req = 0;
    cyc();

    // Reset right after a host read grant; request retried after release
    host_req = 1; host_we = 0; host_addr = 10'h3FF;
    cyc();
    rst_cycle();
    cyc();
    host_req = 0;
    check("t5_host_done",  host_done,  1'b1);
    check("t5_host_rdata", host_rdata, 32'hDEAD_BEEF);
    cyc();

    // Stall accumulation, then clear held across a stalling cycle
    cpu_ren = 1; cpu_addr = 10'h012; host_we = 0; host_addr = 10'h006;
    for (int i = 0; i < 12; i++) begin
      if (!host_req) host_req = 1;
      cyc();
      if (m_gh) host_req = 0;
    end
    check("t6_stall_accum", stall_cnt, 32'd2);
    stall_cnt_clr = 1;
    for (int i = 0; i < 6; i++) begin
      if (!host_req) host_req = 1;
      cyc();
      if (m_gh) host_req = 0;
    end
    check("t6_clr_wins", stall_cnt, 32'd0);
    stall_cnt_clr = 0; cpu_ren = 0; host_req = 0;

    // Saturation and clear priority on a narrow counter
    for (int i = 1; i <= 7; i++) begin
      sc_inc = 1;
      cyc();
      check("sc_sat", sc_q, (i > 5) ? 5 : i);
    end
    sc_clr = 1;
    cyc();
    check("sc_clr_wins", sc_q, 3'd0);
    sc_clr = 0; sc_inc = 0;

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      enable = ($urandom_range(0, 7) != 0);
      op = $urandom_range(0, 3);
      cpu_ren   = (op == 1 || op == 3);
      cpu_wen   = (op == 2);
      cpu_addr  = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
      cpu_wdata = $urandom;
      stall_cnt_clr = ($urandom_range(0, 31) == 0);
      if (!host_req && $urandom_range(0, 2) == 0) new_host_req();
      if ($urandom_range(0, 499) == 0) begin
        rst_cycle();
      end else begin
        cyc();
        if (m_gh) begin
          host_req = 1'b0;
          if ($urandom_range(0, 3) == 0) new_host_req();
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
